// File: rtl/gpu_cmd_pkg.sv
// Shared constants, field map and state type for the GPU instruction path
// (cmd_packer producer and the decode consumer).
package gpu_cmd_pkg;

  localparam int CMD_W      = 82;
  localparam int HOST_W     = 16;
  localparam int BEATS      = 6;
  localparam int STAGE_W    = HOST_W * BEATS;
  localparam int HDR_W      = STAGE_W - CMD_W;
  localparam int BEAT_CNT_W = 3;

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

  localparam int COORD_LSB = 34;
  localparam int COORD_W   = 48;
  localparam int ALPHA_LSB = 30;
  localparam int ALPHA_W   = 4;
  localparam int TEX_LSB   = 28;
  localparam int TEX_W     = 2;
  localparam int COLOR_LSB = 4;
  localparam int COLOR_W   = 24;
  localparam int LAYER_BIT = 3;
  localparam int VERT_BIT  = 2;
  localparam int INST_BIT  = 1;
  localparam int FILL_BIT  = 0;

  // Packed view of one instruction word, MSB field first.
  typedef struct packed {
    logic [COORD_W-1:0] coords;
    logic [ALPHA_W-1:0] alpha_val;
    logic [TEX_W-1:0]   texture_code;
    logic [COLOR_W-1:0] color_code;
    logic               layer_num;
    logic               vertice_num;
    logic               inst_type;
    logic               fill_type;
  } cmd_word_t;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PUSH    = 1'b1
  } cmd_state_e;

  function automatic cmd_word_t cmd_unpack(input logic [CMD_W-1:0] word);
    return cmd_word_t'(word);
  endfunction

  function automatic logic [COORD_W-1:0] cmd_coords(input logic [CMD_W-1:0] word);
    return word[COORD_LSB +: COORD_W];
  endfunction

  function automatic logic [COLOR_W-1:0] cmd_color(input logic [CMD_W-1:0] word);
    return word[COLOR_LSB +: COLOR_W];
  endfunction

endpackage

// File: rtl/cmd_beat_shift.sv
// Staging shift register and beat counter for cmd_packer.
// CMD_HDR_CHECK_EN keeps the reserved header bits so they can be checked.
module cmd_beat_shift
  import gpu_cmd_pkg::*;
(
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_clear,
  input  logic                  i_shift,
  input  logic [HOST_W-1:0]     i_data,
  output logic [CMD_W-1:0]      o_word,
  output logic                  o_hdr_err,
  output logic [BEAT_CNT_W-1:0] o_count,
  output logic                  o_last_beat
);

  // Beat 5 is consumed straight from i_data, so only beats 0..4 are held;
  // the header bits are stored only when the header check is built in.
`ifdef CMD_HDR_CHECK_EN
  localparam int KEEP_W = STAGE_W - HOST_W;
`else
  localparam int KEEP_W = CMD_W - HOST_W;
`endif

  logic [KEEP_W-1:0]     r_stage;
  logic [BEAT_CNT_W-1:0] r_count;

  assign o_count     = r_count;
  assign o_last_beat = i_shift && (r_count == LAST_BEAT);
  assign o_word      = {r_stage[CMD_W-HOST_W-1:0], i_data};

`ifdef CMD_HDR_CHECK_EN
  assign o_hdr_err = |r_stage[KEEP_W-1:CMD_W-HOST_W];
`else
  assign o_hdr_err = 1'b0;
`endif

  // Shift beats in MSB-first and track the beat position within a word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_stage <= {KEEP_W{1'b0}};
      r_count <= {BEAT_CNT_W{1'b0}};
    end else if (i_clear) begin
      r_stage <= {KEEP_W{1'b0}};
      r_count <= {BEAT_CNT_W{1'b0}};
    end else if (i_shift) begin
      r_stage <= {r_stage[KEEP_W-HOST_W-1:0], i_data};
      if (r_count == LAST_BEAT) begin
        r_count <= {BEAT_CNT_W{1'b0}};
      end else begin
        r_count <= r_count + BEAT_CNT_W'(1);
      end
    end else begin
      r_stage <= r_stage;
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/cmd_packer.sv
// Packs six 16-bit host beats into one 82-bit instruction and writes it to the
// instruction FIFO. Optional header check: define CMD_HDR_CHECK_EN.
module cmd_packer
  import gpu_cmd_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [HOST_W-1:0] host_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_abort,
  input  logic              fifo_full,
  output logic              fifo_w_enable,
  output logic [CMD_W-1:0]  fifo_w_data,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent,
  output logic              cmd_err
);

  cmd_state_e            r_state;
  logic                  r_host_ready;
  logic [CMD_W-1:0]      r_w_data;
  logic [CNT_W-1:0]      r_words_sent;
  logic                  r_cmd_err;

  logic                  w_xfer;
  logic                  w_clear;
  logic                  w_shift;
  logic                  w_last;
  logic                  w_hdr_err;
  logic [CMD_W-1:0]      w_word;
  logic [BEAT_CNT_W-1:0] w_count;

  // Abort wins over a same-cycle beat; in PUSH no beat can transfer and
  // abort is ignored so the pending word is still written.
  assign w_xfer  = host_valid && r_host_ready;
  assign w_clear = host_abort && (r_state == COLLECT);
  assign w_shift = w_xfer && !host_abort;

  cmd_beat_shift u_shift (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_clear    (w_clear),
    .i_shift    (w_shift),
    .i_data     (host_data),
    .o_word     (w_word),
    .o_hdr_err  (w_hdr_err),
    .o_count    (w_count),
    .o_last_beat(w_last)
  );

  assign host_ready    = r_host_ready;
  assign fifo_w_enable = (r_state == PUSH) && !fifo_full;
  assign fifo_w_data   = r_w_data;
  assign busy          = (r_state == PUSH) || (w_count != {BEAT_CNT_W{1'b0}});
  assign words_sent    = r_words_sent;
  assign cmd_err       = r_cmd_err;

  // Collect/push control with registered handshake, data, count and error.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= COLLECT;
      r_host_ready <= 1'b1;
      r_w_data     <= {CMD_W{1'b0}};
      r_words_sent <= {CNT_W{1'b0}};
      r_cmd_err    <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_last) begin
            if (w_hdr_err) begin
              r_cmd_err <= 1'b1;
            end else begin
              r_w_data     <= w_word;
              r_state      <= PUSH;
              r_host_ready <= 1'b0;
            end
          end else begin
            r_state <= COLLECT;
          end
        end
        PUSH: begin
          if (!fifo_full) begin
            r_words_sent <= r_words_sent + CNT_W'(1);
            r_state      <= COLLECT;
            r_host_ready <= 1'b1;
          end else begin
            r_state <= PUSH;
          end
        end
        default: begin
          r_state      <= COLLECT;
          r_host_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
